// File: rtl/instr_fetch_queue.sv
// Instruction fetcher with a DEPTH-entry queue and FETCH/HOLD/DROP control.
// Define IFQ_BYPASS_EN to forward an acked word straight to Instr when empty.
module instr_fetch_queue #(
    parameter int         DEPTH      = 4,
    parameter logic [7:0] RESET_ADDR = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Redirect,
    input  logic [7:0]  RedirectAdr,
    output logic        ImemReq,
    output logic [7:0]  ImemAdr,
    input  logic        ImemAck,
    input  logic [15:0] ImemData,
    output logic [15:0] Instr,
    output logic [7:0]  InstrPC,
    output logic        InstrValid,
    input  logic        InstrTake,
    output logic [3:0]  QueueCount
);
    localparam int         AW   = $clog2(DEPTH);
    localparam logic [3:0] FULL = 4'(DEPTH);

    typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

    state_t        state;
    logic [7:0]    fetch_ptr;
    logic [7:0]    adr_q;
    logic [15:0]   data_mem [DEPTH];
    logic [7:0]    pc_mem   [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [3:0]    count;

    logic empty;
    logic full;
    logic fetch_ack;
    logic byp;
    logic push;
    logic pop;

    assign empty     = count == 4'd0;
    assign full      = count == FULL;
    assign fetch_ack = state == FETCH && ImemAck && !Redirect;
`ifdef IFQ_BYPASS_EN
    assign byp       = fetch_ack && empty;
`else
    assign byp       = 1'b0;
`endif
    assign push      = fetch_ack && !full && !(byp && InstrTake);
    assign pop       = !empty && InstrTake && !Redirect;

    assign ImemReq    = !reset && state != HOLD;
    assign ImemAdr    = reset ? RESET_ADDR : adr_q;
    assign QueueCount = reset ? 4'd0 : count;

    always_comb begin
        InstrValid = 1'b0;
        Instr      = 16'h0000;
        InstrPC    = 8'h00;
        if (!reset && !empty) begin
            InstrValid = 1'b1;
            Instr      = data_mem[rd_ptr];
            InstrPC    = pc_mem[rd_ptr];
        end else if (!reset && byp) begin
            InstrValid = 1'b1;
            Instr      = ImemData;
            InstrPC    = adr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            data_mem[wr_ptr] <= ImemData;
            pc_mem[wr_ptr]   <= adr_q;
        end
    end

    // adr_q is the address on the bus; in DROP it keeps the abandoned
    // request's address while fetch_ptr already holds the new target.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            fetch_ptr <= RESET_ADDR;
            adr_q     <= RESET_ADDR;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= 4'd0;
        end else begin
            if (Redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= 4'd0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + {3'b000, push} - {3'b000, pop};
            end
            unique case (state)
                FETCH: begin
                    if (Redirect) begin
                        fetch_ptr <= RedirectAdr;
                        if (ImemAck) adr_q <= RedirectAdr;
                        else         state <= DROP;
                    end else if (ImemAck) begin
                        fetch_ptr <= adr_q + 8'd4;
                        adr_q     <= adr_q + 8'd4;
                        if (push && !pop && count == FULL - 4'd1)
                            state <= HOLD;
                    end
                end
                HOLD: begin
                    if (Redirect) begin
                        fetch_ptr <= RedirectAdr;
                        adr_q     <= RedirectAdr;
                        state     <= FETCH;
                    end else if (!full) begin
                        state <= FETCH;
                    end
                end
                DROP: begin
                    if (Redirect) fetch_ptr <= RedirectAdr;
                    if (ImemAck) begin
                        state <= FETCH;
                        adr_q <= Redirect ? RedirectAdr : fetch_ptr;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: queue-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_instr_fetch_queue;
    localparam int         DEPTH   = 4;
    localparam logic [7:0] RST_ADR = 8'h00;

    logic        clk = 1'b0;
    logic        reset;
    logic        Redirect;
    logic [7:0]  RedirectAdr;
    logic        ImemReq;
    logic [7:0]  ImemAdr;
    logic        ImemAck;
    logic [15:0] ImemData;
    logic [15:0] Instr;
    logic [7:0]  InstrPC;
    logic        InstrValid;
    logic        InstrTake;
    logic [3:0]  QueueCount;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_ADDR(RST_ADR)) dut (
        .clk(clk), .reset(reset),
        .Redirect(Redirect), .RedirectAdr(RedirectAdr),
        .ImemReq(ImemReq), .ImemAdr(ImemAdr),
        .ImemAck(ImemAck), .ImemData(ImemData),
        .Instr(Instr), .InstrPC(InstrPC), .InstrValid(InstrValid),
        .InstrTake(InstrTake), .QueueCount(QueueCount)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {data, pc}, the next fetch address, the
    // address currently on the bus, and whether a request is outstanding
    // (m_req) and whose answer must be thrown away (m_drop).
    logic [23:0] mq[$];
    logic [7:0]  m_ptr;
    logic [7:0]  m_adr;
    bit          m_req;
    bit          m_drop;
    bit          m_live = 1'b0;

    function automatic bit m_byp();
`ifdef IFQ_BYPASS_EN
        return !reset && m_req && !m_drop && ImemAck && !Redirect && mq.size() == 0;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        int sz;
        bit ack;
        bit tk;
        if (reset) begin
            mq.delete();
            m_ptr  = RST_ADR;
            m_adr  = RST_ADR;
            m_req  = 1'b1;
            m_drop = 1'b0;
            m_live = 1'b1;
        end else if (m_live) begin
            sz  = mq.size();
            ack = ImemAck && m_req;
            tk  = m_byp() && InstrTake;
            if (Redirect) begin
                mq.delete();
                m_ptr = RedirectAdr;
                if (m_req && !ack) begin
                    m_drop = 1'b1;
                end else begin
                    m_req  = 1'b1;
                    m_drop = 1'b0;
                    m_adr  = RedirectAdr;
                end
            end else begin
                if (sz != 0 && InstrTake) void'(mq.pop_front());
                if (ack && m_drop) begin
                    m_drop = 1'b0;
                    m_adr  = m_ptr;
                end else if (ack) begin
                    if (!tk) mq.push_back({ImemData, m_adr});
                    m_adr = m_adr + 8'd4;
                    m_ptr = m_adr;
                    if (!tk && mq.size() == DEPTH) m_req = 1'b0;
                end else if (!m_req && sz < DEPTH) begin
                    m_req = 1'b1;
                end
            end
        end
    end

    logic        e_valid;
    logic [15:0] e_instr;
    logic [7:0]  e_pc;

    always @(negedge clk) begin
        #1;
        if (m_live) begin
            e_valid = 1'b0;
            e_instr = 16'h0000;
            e_pc    = 8'h00;
            if (!reset && mq.size() != 0) begin
                e_valid = 1'b1;
                e_instr = mq[0][23:8];
                e_pc    = mq[0][7:0];
            end else if (m_byp()) begin
                e_valid = 1'b1;
                e_instr = ImemData;
                e_pc    = m_adr;
            end
            chk("m_req", ImemReq, !reset && m_req);
            chk("m_adr", ImemAdr, reset ? RST_ADR : m_adr);
            chk("m_count", QueueCount, reset ? 0 : mq.size());
            chk("m_valid", InstrValid, e_valid);
            chk("m_instr", Instr, e_instr);
            chk("m_pc", InstrPC, e_pc);
        end
    end

    // dx = 0 selects the default memory word 16'hA000 + address
    task automatic step(input bit r, input bit rd, input logic [7:0] ra,
                        input bit ak, input bit tk,
                        input logic [15:0] dx = 16'h0000);
        @(negedge clk);
        reset       = r;
        Redirect    = rd;
        RedirectAdr = ra;
        ImemAck     = ak;
        ImemData    = (dx != 16'h0000) ? dx : 16'hA000 + {8'h00, m_adr};
        InstrTake   = tk;
        #2;
    endtask

    task automatic rstep(input int take_pct);
        @(negedge clk);
        reset       = $urandom_range(0, 299) == 0;
        Redirect    = $urandom_range(0, 11) == 0;
        RedirectAdr = 8'($urandom);
        ImemAck     = m_req && $urandom_range(0, 2) != 0;
        ImemData    = 16'($urandom);
        InstrTake   = $urandom_range(0, 99) < take_pct;
        #2;
    endtask

    initial begin
        reset = 1'b1; Redirect = 1'b0; RedirectAdr = 8'h00;
        ImemAck = 1'b0; ImemData = 16'h0000; InstrTake = 1'b0;

        step(1, 0, 8'h00, 0, 0);
        step(1, 0, 8'h00, 1, 0);
        chk("rst_req", ImemReq, 0);
        chk("rst_valid", InstrValid, 0);
        chk("rst_count", QueueCount, 0);
        chk("rst_instr", Instr, 16'h0000);
        chk("rst_pc", InstrPC, 8'h00);
        chk("rst_adr", ImemAdr, RST_ADR);

        for (int i = 0; i < 4; i++) begin
            step(0, 0, 8'h00, 1, 0);
            chk("fill_req", ImemReq, 1);
            chk("fill_adr", ImemAdr, 4 * i);
        end
        step(0, 0, 8'h00, 0, 0);
        chk("full_count", QueueCount, 4);
        chk("hold_req", ImemReq, 0);

        step(0, 0, 8'h00, 0, 1);
        chk("pop_instr", Instr, 16'hA000);
        chk("pop_pc", InstrPC, 8'h00);
        step(0, 0, 8'h00, 0, 0);
        chk("pop_count", QueueCount, 3);
        step(0, 0, 8'h00, 0, 0);
        chk("refill_req", ImemReq, 1);
        chk("refill_adr", ImemAdr, 8'h10);
        chk("refill_head", Instr, 16'hA004);

        step(1, 0, 8'h00, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 1, 0);
        step(0, 1, 8'h40, 0, 0);
        chk("drop_req_adr", ImemAdr, 8'h08);
        step(0, 0, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        chk("drop_hold_adr", ImemAdr, 8'h08);
        chk("drop_valid", InstrValid, 0);
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 0, 0);
        chk("drop_next_adr", ImemAdr, 8'h40);
        chk("drop_discard", InstrValid, 0);
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 0, 0);
        chk("drop_first_pc", InstrPC, 8'h40);
        chk("drop_first_ins", Instr, 16'hA040);

        step(0, 0, 8'h00, 1, 0);
        step(0, 1, 8'h80, 1, 0, 16'hBEEF);
        chk("redack_pre_cnt", QueueCount, 2);
        step(0, 0, 8'h00, 0, 0);
        chk("redack_count", QueueCount, 0);
        chk("redack_adr", ImemAdr, 8'h80);
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 0, 0);
        chk("redack_instr", Instr, 16'hA080);
        chk("redack_pc", InstrPC, 8'h80);

        step(0, 1, 8'hFC, 1, 0);
        step(0, 0, 8'h00, 1, 0);
        chk("wrap_req_adr", ImemAdr, 8'hFC);
        step(0, 0, 8'h00, 0, 0);
        chk("wrap_adr", ImemAdr, 8'h00);
        chk("wrap_pc", InstrPC, 8'hFC);
        chk("wrap_instr", Instr, 16'hA0FC);

        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 0, 0);
        chk("mid_count", QueueCount, 3);
        chk("mid_req", ImemReq, 1);
        step(1, 0, 8'h00, 1, 0);
        chk("mid_rst_req", ImemReq, 0);
        step(0, 0, 8'h00, 0, 0);
        chk("mid_rel_count", QueueCount, 0);
        chk("mid_rel_adr", ImemAdr, RST_ADR);
        chk("mid_rel_req", ImemReq, 1);

`ifdef IFQ_BYPASS_EN
        step(0, 0, 8'h00, 1, 1);
        chk("byp_valid", InstrValid, 1);
        chk("byp_instr", Instr, 16'hA000);
        step(0, 0, 8'h00, 0, 0);
        chk("byp_count", QueueCount, 0);
`endif

        for (int n = 0; n < 1500; n++) rstep(20);
        for (int n = 0; n < 1500; n++) rstep(50);
        for (int n = 0; n < 1500; n++) rstep(90);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
